// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-754 single-precision multiplier with valid/ready handshake and sideband tag
//   params : STAGES (2..4) pipeline depth, TAG_W tag width
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; x1, x2 operands; in_tag sideband tag
//   out_valid/out_ready result handshake; y product; out_tag tag; flags {ovf, udf}
//   FMUL_PIPE_RNE_EN    define for round-to-nearest-even, otherwise the mantissa is truncated
module fmul_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       flags
);
  logic             adv;
  logic             v1, s1, z1, i1;
  logic [9:0]       e1;
  logic [35:0]      pl1, ph1;
  logic [TAG_W-1:0] t1;
  logic [47:0]      p;
  logic             hi, udf, ovf;
  logic [9:0]       e_n, e_f;
  logic [22:0]      mant, m_f;
  logic [31:0]      y_n;
  logic             rv [2:STAGES];
  logic [31:0]      ry [2:STAGES];
  logic [TAG_W-1:0] rt [2:STAGES];
  logic [1:0]       rf [2:STAGES];
  assign out_valid = rv[STAGES];
  assign y         = ry[STAGES];
  assign out_tag   = rt[STAGES];
  assign flags     = rf[STAGES];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  // Stage 1: classify operands, pre-bias the exponent, form two 24x12 partial products
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      s1  <= 1'b0;
      z1  <= 1'b0;
      i1  <= 1'b0;
      e1  <= '0;
      pl1 <= '0;
      ph1 <= '0;
      t1  <= '0;
    end else if (adv) begin
      v1  <= in_valid;
      s1  <= x1[31] ^ x2[31];
      z1  <= (x1[30:23] == 8'h00) | (x2[30:23] == 8'h00);
      i1  <= (x1[30:23] == 8'hff) | (x2[30:23] == 8'hff);
      e1  <= {2'b00, x1[30:23]} + {2'b00, x2[30:23]} - 10'd127;
      pl1 <= {12'b0, 1'b1, x1[22:0]} * {24'b0, x2[11:0]};
      ph1 <= {12'b0, 1'b1, x1[22:0]} * {24'b0, 1'b1, x2[22:12]};
      t1  <= in_tag;
    end
  end
  // Stage 2: combine partials, normalise, round, resolve specials
  assign p    = {12'b0, pl1} + {ph1, 12'b0};
  assign hi   = p[47];
  assign e_n  = e1 + {9'b0, hi};
  assign mant = hi ? p[46:24] : p[45:23];
`ifdef FMUL_PIPE_RNE_EN
  logic        g, st;
  logic [23:0] mr;
  assign g   = hi ? p[23] : p[22];
  assign st  = hi ? |p[22:0] : |p[21:0];
  assign mr  = {1'b0, mant} + {23'b0, g & (st | mant[0])};
  // a carry out of the mantissa leaves mr[22:0] at zero and bumps the exponent
  assign e_f = e_n + {9'b0, mr[23]};
  assign m_f = mr[22:0];
`else
  logic unused_low;
  assign unused_low = ^p[22:0];
  assign e_f = e_n;
  assign m_f = mant;
`endif
  assign udf = z1 | ($signed(e_f) <= 10'sd0);
  assign ovf = ~udf & (i1 | ($signed(e_f) >= 10'sd255));
  assign y_n = udf ? {s1, 31'b0} : ovf ? {s1, 8'hff, 23'b0} : {s1, e_f[7:0], m_f};
  // Stage 2 result register followed by STAGES-2 retiming registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 2; i <= STAGES; i++) begin
        rv[i] <= 1'b0;
        ry[i] <= '0;
        rt[i] <= '0;
        rf[i] <= '0;
      end
    end else if (adv) begin
      rv[2] <= v1;
      ry[2] <= y_n;
      rt[2] <= t1;
      rf[2] <= {ovf, udf};
      for (int i = 3; i <= STAGES; i++) begin
        rv[i] <= rv[i-1];
        ry[i] <= ry[i-1];
        rt[i] <= rt[i-1];
        rf[i] <= rf[i-1];
      end
    end
  end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: self-checking bench for fmul_pipe against an arithmetic reference model
module tb_fmul_pipe;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [31:0] x1 = '0, x2 = '0, y;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic [1:0] flags;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fmul_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x1(x1), .x2(x2),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag), .flags(flags)
  );
  // {flags, y} from real-valued reasoning: full product, shift to 1.x, optional RNE on the remainder
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s;
    logic [63:0] p, m;
`ifdef FMUL_PIPE_RNE_EN
    logic [63:0] rem, half;
`endif
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    p  = {40'b0, 1'b1, a[22:0]} * {40'b0, 1'b1, b[22:0]};
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin e++; sh = 24; end
    m = (p >> sh) - (64'd1 << 23);
`ifdef FMUL_PIPE_RNE_EN
    rem  = p % (64'd1 << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m++;
    if (m == (64'd1 << 23)) begin m = 0; e++; end
`endif
    if (ea == 0 || eb == 0 || e <= 0) return {2'b01, s, 31'b0};
    if (ea == 255 || eb == 255 || e >= 255) return {2'b10, s, 8'hff, 23'b0};
    return {2'b00, s, e[7:0], m[22:0]};
  endfunction
  function automatic logic [31:0] rand_fp();
    int r;
    logic [7:0] e;
    r = $urandom_range(0, 9);
    e = (r == 0) ? 8'h00 : (r == 1) ? 8'hff : 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset y: got %h expected 00000000", y); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset out_tag: got %h expected 0", out_tag); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL reset flags: got %b expected 00", flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
  endtask
  task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                         input logic [31:0] ey, input logic [1:0] ef, input string nm);
    int n;
    x1 = a;
    x2 = b;
    in_tag = tag;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (n != STAGES) begin errors++; $display("FAIL %s latency: got %0d expected %0d", nm, n, STAGES); end
    checks++; if (y !== ey) begin errors++; $display("FAIL %s y: got %h expected %h", nm, y, ey); end
    checks++; if (out_tag !== tag) begin errors++; $display("FAIL %s out_tag: got %h expected %h", nm, out_tag, tag); end
    checks++; if (flags !== ef) begin errors++; $display("FAIL %s flags: got %b expected %b", nm, flags, ef); end
    tick();
  endtask
  task automatic test_directed();
    run_vec(32'h3FC00000, 32'h40000000, 4'd3, 32'h40400000, 2'b00, "basic");
    run_vec(32'h7F000000, 32'h7F000000, 4'd1, 32'h7F800000, 2'b10, "overflow");
    run_vec(32'h00800000, 32'h00800000, 4'd2, 32'h00000000, 2'b01, "underflow");
    run_vec(32'hFF800000, 32'h00000000, 4'd4, 32'h80000000, 2'b01, "inf_times_zero");
`ifdef FMUL_PIPE_RNE_EN
    run_vec(32'h3F800001, 32'h3FC00000, 4'd6, 32'h3FC00002, 2'b00, "rounding");
`else
    run_vec(32'h3F800001, 32'h3FC00000, 4'd6, 32'h3FC00001, 2'b00, "rounding");
`endif
  endtask
  task automatic test_stall();
    logic [31:0] opa [8], opb [8], held;
    logic [37:0] q [$], ex;
    int sent, got, cyc;
    bit prev_stall;
    for (int i = 0; i < 8; i++) begin opa[i] = rand_fp(); opb[i] = rand_fp(); end
    sent = 0; got = 0; cyc = 0; prev_stall = 0; held = '0;
    while (got < 8 && cyc < 100) begin
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid = (sent < 8);
      if (sent < 8) begin x1 = opa[sent]; x2 = opb[sent]; in_tag = TAG_W'(sent); end
      @(negedge clk);
      if (prev_stall) begin
        checks++; if (y !== held) begin errors++; $display("FAIL stall y_stable: got %h expected %h", y, held); end
      end
      prev_stall = 0;
      if (out_valid && !out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall in_ready: got %b expected 0", in_ready); end
        prev_stall = 1;
        held = y;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL stall extra_output: got tag %h expected none", out_tag); end
        else begin
          ex = q.pop_front();
          if ({flags, y, out_tag} !== ex || out_tag !== TAG_W'(got)) begin
            errors++;
            $display("FAIL stall result %0d: got %b/%h/%h expected %b/%h/%h", got, flags, y, out_tag, ex[37:36], ex[35:4], ex[3:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back({model(opa[sent], opb[sent]), TAG_W'(sent)}); sent++; end
      tick();
      cyc++;
    end
    checks++; if (got != 8) begin errors++; $display("FAIL stall count: got %0d expected 8", got); end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask
  task automatic test_random();
    logic [37:0] q [$], ex;
    logic [31:0] held;
    int sent, got, cyc;
    bit prev_stall;
    sent = 0; got = 0; cyc = 0; prev_stall = 0; held = '0;
    while ((got < 300 || q.size() != 0) && cyc < 3000) begin
      in_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x1 = rand_fp();
      x2 = rand_fp();
      in_tag = TAG_W'($urandom);
      @(negedge clk);
      checks++;
      if (in_ready !== (out_ready | ~out_valid)) begin errors++; $display("FAIL random in_ready: got %b expected %b", in_ready, out_ready | ~out_valid); end
      if (prev_stall) begin
        checks++; if (y !== held) begin errors++; $display("FAIL random y_stable: got %h expected %h", y, held); end
      end
      prev_stall = out_valid && !out_ready;
      held = y;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL random extra_output: got tag %h expected none", out_tag); end
        else begin
          ex = q.pop_front();
          if ({flags, y, out_tag} !== ex) begin
            errors++;
            $display("FAIL random result %0d: got %b/%h/%h expected %b/%h/%h", got, flags, y, out_tag, ex[37:36], ex[35:4], ex[3:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back({model(x1, x2), in_tag}); sent++; end
      tick();
      cyc++;
    end
    checks++; if (got != 300) begin errors++; $display("FAIL random count: got %0d expected 300", got); end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask
  task automatic test_reset_flush();
    bit seen;
    out_ready = 1'b1;
    in_valid = 1'b1;
    x1 = 32'h3FC00000; x2 = 32'h40000000; in_tag = 4'hA;
    tick();
    x1 = 32'h40000000; x2 = 32'h40000000; in_tag = 4'hB;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid: got %b expected 0", out_valid); end
    checks++; if (y !== 32'h0 || flags !== 2'b00 || out_tag !== '0) begin errors++; $display("FAIL flush outputs: got %h/%b/%h expected 0", y, flags, out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready: got %b expected 1", in_ready); end
    seen = 0;
    repeat (8) begin tick(); if (out_valid) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush ghost_output: got %b expected 0", seen); end
    run_vec(32'h40400000, 32'h40000000, 4'd5, 32'h40C00000, 2'b00, "after_reset");
  endtask
  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fmul_pipe.md
FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 Parameter STAGES, default 2, SHALL set pipeline depth; legal range 2..4.
REQ-002 Parameter TAG_W, default 4, SHALL set the width of the sideband tag carried alongside each operation.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 x1, x2  input  32 each  IEEE-754 single-precision operands.
REQ-008 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 y  output  32  product.
REQ-012 out_tag  output  TAG_W  tag of the result on y.
REQ-013 flags  output  2  {ovf, udf} for the result on y.

Function
REQ-014 Transfer SHALL occur on in_valid&in_ready (input side) and on out_valid&out_ready (output side).
REQ-015 Pipeline SHALL advance as a whole when adv = out_ready | ~out_valid; in_ready SHALL equal adv, combinationally.
REQ-016 Latency SHALL be exactly STAGES advancing cycles from input transfer to out_valid.
REQ-017 Results SHALL leave in input order; none SHALL be dropped or duplicated.
REQ-018 While adv=0, y, out_tag and flags SHALL hold stable.
REQ-019 Each stage SHALL carry a valid bit; bubbles (in_valid=0 on advance) SHALL propagate as valid=0.
REQ-020 Mantissa product SHALL be a 24x24 product ({1,m1}*{1,m2}), split as partial products across stages 1..2; stages beyond 2 SHALL be retiming registers on the output.
REQ-021 An operand with e=0 SHALL be treated as zero; an operand with e=255 SHALL be treated as infinity, regardless of mantissa.
REQ-022 The sign of y SHALL be s1^s2 in every case, including zero and infinity.
REQ-023 Biased exponent = e1+e2-127, computed 10-bit signed; +1 when product bit 47 is set.
REQ-024 udf SHALL be 1 if either operand is zero or the final exponent <= 0; y SHALL then be {s,0x00,0}.
REQ-025 ovf SHALL be 1 if udf=0 and (either operand is infinity or the final exponent >= 255); y SHALL then be {s,0xFF,0}.
REQ-026 A zero operand times an infinite operand SHALL yield zero with udf=1 (udf has priority).
REQ-027 Normal result mantissa SHALL be p[46:24] if p[47] else p[45:23], truncated, unless REQ-032 applies.

Reset
REQ-028 On rst, all stage valid bits, out_valid, y, out_tag and flags SHALL be 0 on the next edge.
REQ-029 rst SHALL override any in-flight transfer; operations in flight SHALL be discarded, not completed.
REQ-030 in_ready SHALL be 1 in the first cycle after reset is deasserted.

Configuration
REQ-031 Macro FMUL_PIPE_RNE_EN SHALL select the rounding mode.
REQ-032 With FMUL_PIPE_RNE_EN defined: the mantissa SHALL round to nearest, ties to even, using guard and sticky bits. A rounding carry out SHALL increment the exponent and be re-checked against REQ-025.
REQ-033 Without FMUL_PIPE_RNE_EN: truncation per REQ-027, and no rounding logic SHALL be synthesised.

Verification
REQ-034 0x3FC00000*0x40000000, tag 3 -> y=0x40400000, out_tag=3, flags=00, out_valid exactly STAGES cycles after accept.
REQ-035 0x7F000000*0x7F000000 -> y=0x7F800000, flags=10. 0x00800000*0x00800000 -> y=0x00000000, flags=01. 0xFF800000*0x00000000 -> y=0x80000000, flags=01.
REQ-036 0x3F800001*0x3FC00000 -> y=0x3FC00001 without the macro; y=0x3FC00002 with FMUL_PIPE_RNE_EN.
REQ-037 Stream 8 ops with tags 0..7 while holding out_ready=0 from cycle 3 for 5 cycles. Expected: in_ready=0 while out_valid=1, y stable, all 8 tags out in order after release.
REQ-038 Assert rst for 1 cycle with 2 ops in flight -> out_valid=0 next cycle; neither op appears; a new op issued after reset completes normally.
